// File: rtl/spi_pkg.sv
// spi_pkg: shared types and default parameters for the SPI master.
//   spi_mst_state_t : master FSM state encoding
//   SPI_*           : default generics used by spi_master
//   spi_max3        : helper to size the shared phase counter
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_mst_state_t;

  localparam int SPI_CLK_DIV  = 4;
  localparam int SPI_DATA_W   = 8;
  localparam int SPI_SS_SETUP = 2;
  localparam int SPI_SS_HOLD  = 2;
  localparam int SPI_CS_GAP   = 4;

  function automatic int spi_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCLK generator for the SPI master.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   en_i   : run the half-period counter (low forces sclk low, counter cleared)
//   sclk_o : registered SPI clock, starts low when enabled
//   rise_o : one-cycle strobe, sclk_o goes high at the coming clk edge
//   fall_o : one-cycle strobe, sclk_o goes low at the coming clk edge
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  // A half period ends when the counter reaches CLK_DIV-1; sclk toggles there.
  assign wrap = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en_i) begin
      cnt_d  = wrap ? '0 : cnt_q + CW'(1);
      sclk_d = wrap ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap && sclk_q;

endmodule

// File: rtl/spi_master.sv
// spi_master: single-clock SPI mode-0 master, one word per frame.
//   clk, rst            : system clock, synchronous active-high reset
//   tx_data, tx_valid   : word to send / start request
//   tx_ready            : high only in IDLE
//   rx_data, rx_valid   : received word, one-cycle strobe on completion
//   busy                : high whenever not IDLE
//   sclk, mosi, ss_n    : registered SPI outputs
//   miso                : SPI data in (same clock domain)
//   state_o             : current FSM state, for observation
// Handshake: a word is accepted on a clk edge where tx_valid && tx_ready;
// tx_data is sampled only on that edge, and tx_valid while busy is dropped.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = SPI_CLK_DIV,
  parameter int DATA_W   = SPI_DATA_W,
  parameter int SS_SETUP = SPI_SS_SETUP,
  parameter int SS_HOLD  = SPI_SS_HOLD,
  parameter int CS_GAP   = SPI_CS_GAP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic                ss_n,
  output spi_mst_state_t      state_o
);

  localparam int PH_MAX = spi_max3(SS_SETUP, SS_HOLD, CS_GAP);
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int BW     = $clog2(DATA_W + 1);

  localparam logic [PW-1:0] PH_SETUP_LAST = PW'(SS_SETUP - 1);
  localparam logic [PW-1:0] PH_HOLD_LAST  = PW'(SS_HOLD - 1);
  localparam logic [PW-1:0] PH_GAP_LAST   = PW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST      = BW'(DATA_W - 1);

  spi_mst_state_t      state_q, state_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                cap_q, cap_d;
  logic                mosi_q, mosi_d;
  logic                ss_n_q, ss_n_d;
  logic                rx_valid_q, rx_valid_d;

  logic div_en, div_rise, div_fall;

  assign div_en = (state_q == XFER);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (div_en),
    .sclk_o (sclk),
    .rise_o (div_rise),
    .fall_o (div_fall)
  );

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    rx_valid_d = 1'b0;
    // cap_q marks the first cycle of a high phase; miso is sampled at its end.
    cap_d      = div_rise;

    if (cap_q) begin
      rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = SETUP;
          ph_d    = '0;
          bit_d   = '0;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          mosi_d  = tx_data[DATA_W-1];
          ss_n_d  = 1'b0;
        end
      end
      SETUP: begin
        if (ph_q == PH_SETUP_LAST) begin
          state_d = XFER;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      XFER: begin
        // Falls launch the next bit; the last fall closes the transfer and
        // leaves mosi on the final bit.
        if (div_fall) begin
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_q[DATA_W-2];
          end
        end
      end
      HOLD: begin
        if (ph_q == PH_HOLD_LAST) begin
          state_d    = GAP;
          ph_d       = '0;
          ss_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      GAP: begin
        if (ph_q == PH_GAP_LAST) begin
          state_d = IDLE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cap_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cap_q      <= cap_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign state_o  = state_q;

endmodule
